// File: rtl/image_conv_quant_pkg.sv
// Shared definitions for the conv requantization stage: lane-count macros,
// default widths and the channel-group helper.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef QUANT_SCALE_WIDTH
`define QUANT_SCALE_WIDTH 32
`endif
`ifndef QUANT_SHIFT_WIDTH
`define QUANT_SHIFT_WIDTH 6
`endif

package image_conv_quant_pkg;

    localparam int PICTURE_NUM             = `PICTURE_NUM;
    localparam int DEF_WIDTH_DATA_IN       = 48;
    localparam int DEF_WIDTH_SCALE         = `QUANT_SCALE_WIDTH;
    localparam int DEF_WIDTH_SHIFT         = `QUANT_SHIFT_WIDTH;
    localparam int DEF_WIDTH_DATA_OUT      = 8;
    localparam int DEF_CHANNEL_OUT_NUM     = 8;
    localparam int DEF_WIDTH_FEATURE_SIZE  = 10;

    typedef struct packed {
        logic valid;
        logic last;
    } beat_tag_t;

    // Number of 8-channel groups in the layer; an empty layer still counts as one group.
    function automatic logic [4:0] channel_times(input logic [7:0] ch_num);
        logic [4:0] t;
        t = 5'(ch_num >> 3);
        if (t == 5'd0) begin
            t = 5'd1;
        end else begin
            t = t;
        end
        return t;
    endfunction

endpackage

// File: rtl/image_quant_lane.sv
// One requantization lane: scale multiply, round-half-up, arithmetic shift,
// zero-point add and int8 saturation over four register stages.
module image_quant_lane
    import image_conv_quant_pkg::*;
#(
    parameter int WIDTH_DATA_IN  = DEF_WIDTH_DATA_IN,
    parameter int WIDTH_SCALE    = DEF_WIDTH_SCALE,
    parameter int WIDTH_SHIFT    = DEF_WIDTH_SHIFT,
    parameter int WIDTH_DATA_OUT = DEF_WIDTH_DATA_OUT,
    parameter int WIDTH_ZP       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [WIDTH_DATA_IN-1:0]    data_in,
    input  logic signed [WIDTH_SCALE-1:0]      scale,
    input  logic        [WIDTH_SHIFT-1:0]      shift,
    input  logic signed [WIDTH_ZP-1:0]         zero_point,
    output logic signed [WIDTH_DATA_OUT-1:0]   data_out
);

    localparam int WP = WIDTH_DATA_IN + WIDTH_SCALE;
    localparam logic signed [WP:0] SAT_MAX = (WP+1)'((2 ** (WIDTH_DATA_OUT-1)) - 1);
    localparam logic signed [WP:0] SAT_MIN = ~SAT_MAX;

    logic signed [WP-1:0]             data_ext_s;
    logic signed [WP-1:0]             scale_ext_s;
    logic signed [WP-1:0]             prod_r;
    logic signed [WP-1:0]             rnd_r;
    logic signed [WP-1:0]             quo_r;
    logic        [WIDTH_SHIFT-1:0]    shift1_r;
    logic        [WIDTH_SHIFT-1:0]    shift2_r;
    logic signed [WP:0]               sum_s;
    logic signed [WIDTH_DATA_OUT-1:0] sat_s;

    // Half of the last retained LSB, so the shift rounds half up.
    function automatic logic [WP-1:0] round_bias(input logic [WIDTH_SHIFT-1:0] sh);
        logic [WP-1:0] b;
        b = '0;
        if (sh != '0) begin
            b[sh - WIDTH_SHIFT'(1)] = 1'b1;
        end else begin
            b = '0;
        end
        return b;
    endfunction

    // Sign-extend operands to the full product width.
    always_comb begin
        data_ext_s  = WP'(data_in);
        scale_ext_s = WP'(scale);
    end

    // Zero-point add in one extra bit, then clamp to the output range.
    always_comb begin
        sum_s = (WP+1)'(quo_r) + (WP+1)'(zero_point);
        sat_s = sum_s[WIDTH_DATA_OUT-1:0];
        if (sum_s > SAT_MAX) begin
            sat_s = SAT_MAX[WIDTH_DATA_OUT-1:0];
        end else if (sum_s < SAT_MIN) begin
            sat_s = SAT_MIN[WIDTH_DATA_OUT-1:0];
        end else begin
            sat_s = sum_s[WIDTH_DATA_OUT-1:0];
        end
    end

    // Four-stage datapath; the shift amount travels alongside the product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r   <= '0;
            shift1_r <= '0;
            rnd_r    <= '0;
            shift2_r <= '0;
            quo_r    <= '0;
            data_out <= '0;
        end else begin
            prod_r   <= data_ext_s * scale_ext_s;
            shift1_r <= shift;
            rnd_r    <= prod_r + $signed(round_bias(shift1_r));
            shift2_r <= shift1_r;
            quo_r    <= rnd_r >>> shift2_r;
            data_out <= sat_s;
        end
    end

endmodule

// File: rtl/image_conv_quant.sv
// Requantization stage after conv bias-add: channel-group tracking, valid/last
// pipeline and per-channel parameter fan-out to the lane array.
module image_conv_quant
    import image_conv_quant_pkg::*;
#(
    parameter int WIDTH_DATA_IN           = DEF_WIDTH_DATA_IN,
    parameter int WIDTH_SCALE             = DEF_WIDTH_SCALE,
    parameter int WIDTH_SHIFT             = DEF_WIDTH_SHIFT,
    parameter int WIDTH_DATA_OUT          = DEF_WIDTH_DATA_OUT,
    parameter int COMPUTE_CHANNEL_OUT_NUM = DEF_CHANNEL_OUT_NUM,
    parameter int WIDTH_FEATURE_SIZE      = DEF_WIDTH_FEATURE_SIZE
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        start,
    input  logic [7:0]                                                  Channel_Out_Num_REG,
    input  logic [WIDTH_DATA_IN*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0]  S_Data,
    input  logic                                                        S_Valid,
    input  logic [WIDTH_SCALE*COMPUTE_CHANNEL_OUT_NUM-1:0]              scale_data_in,
    input  logic [WIDTH_SHIFT*COMPUTE_CHANNEL_OUT_NUM-1:0]              shift_data_in,
    input  logic [7:0]                                                  zero_point,
    output logic [WIDTH_FEATURE_SIZE:0]                                 param_group,
    output logic [WIDTH_DATA_OUT*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0] M_Data,
    output logic                                                        M_Valid,
    output logic                                                        M_Last_Group
);

    localparam int LANES = PICTURE_NUM * COMPUTE_CHANNEL_OUT_NUM;
    localparam int WG    = WIDTH_FEATURE_SIZE + 1;

    logic [4:0]    channel_times_s;
    logic [WG-1:0] last_group_s;
    logic          last_beat_s;
    logic [WG-1:0] group_next_s;
    beat_tag_t     tag_r [3];

    // Decode the final group index of the layer.
    always_comb begin
        channel_times_s = channel_times(Channel_Out_Num_REG);
        last_group_s    = WG'(channel_times_s - 5'd1);
        last_beat_s     = (param_group == last_group_s);
    end

    // Start clears the group ahead of any beat in the same cycle.
    always_comb begin
        group_next_s = param_group;
        if (start) begin
            group_next_s = '0;
        end else if (S_Valid) begin
            if (last_beat_s) begin
                group_next_s = '0;
            end else begin
                group_next_s = param_group + WG'(1);
            end
        end else begin
            group_next_s = param_group;
        end
    end

    // Group counter register; addresses the parameter memory directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            param_group <= '0;
        end else begin
            param_group <= group_next_s;
        end
    end

    // Valid/last tags ride alongside the lane datapath with matching latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r[0]     <= '0;
            tag_r[1]     <= '0;
            tag_r[2]     <= '0;
            M_Valid      <= 1'b0;
            M_Last_Group <= 1'b0;
        end else begin
            tag_r[0]     <= '{valid: S_Valid, last: S_Valid & last_beat_s};
            tag_r[1]     <= tag_r[0];
            tag_r[2]     <= tag_r[1];
            M_Valid      <= tag_r[2].valid;
            M_Last_Group <= tag_r[2].last;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int CH = k / PICTURE_NUM;
        image_quant_lane #(
            .WIDTH_DATA_IN  (WIDTH_DATA_IN),
            .WIDTH_SCALE    (WIDTH_SCALE),
            .WIDTH_SHIFT    (WIDTH_SHIFT),
            .WIDTH_DATA_OUT (WIDTH_DATA_OUT),
            .WIDTH_ZP       (8)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .data_in    (S_Data[k*WIDTH_DATA_IN +: WIDTH_DATA_IN]),
            .scale      (scale_data_in[CH*WIDTH_SCALE +: WIDTH_SCALE]),
            .shift      (shift_data_in[CH*WIDTH_SHIFT +: WIDTH_SHIFT]),
            .zero_point (zero_point),
            .data_out   (M_Data[k*WIDTH_DATA_OUT +: WIDTH_DATA_OUT])
        );
    end

endmodule

// File: tb/tb_image_conv_quant.sv
// Directed bench for image_conv_quant: rounding, saturation, group counter,
// start-pulse and mid-stream reset behaviour.
module tb_image_conv_quant;
    import image_conv_quant_pkg::*;

    localparam int NL = PICTURE_NUM * DEF_CHANNEL_OUT_NUM;
    localparam int NC = DEF_CHANNEL_OUT_NUM;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [7:0]          Channel_Out_Num_REG;
    logic [48*NL-1:0]    S_Data;
    logic                S_Valid;
    logic [32*NC-1:0]    scale_data_in;
    logic [6*NC-1:0]     shift_data_in;
    logic [7:0]          zero_point;
    logic [10:0]         param_group;
    logic [8*NL-1:0]     M_Data;
    logic                M_Valid;
    logic                M_Last_Group;

    int checks = 0;
    int errors = 0;

    image_conv_quant dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .Channel_Out_Num_REG (Channel_Out_Num_REG),
        .S_Data              (S_Data),
        .S_Valid             (S_Valid),
        .scale_data_in       (scale_data_in),
        .shift_data_in       (shift_data_in),
        .zero_point          (zero_point),
        .param_group         (param_group),
        .M_Data              (M_Data),
        .M_Valid             (M_Valid),
        .M_Last_Group        (M_Last_Group)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_out(input int k);
        logic signed [7:0] v;
        v = M_Data[k*8 +: 8];
        return longint'(v);
    endfunction

    task automatic set_beat(input longint a, input longint sca, input int sha,
                            input longint b, input longint scb, input int shb);
        S_Data        = '0;
        scale_data_in = '0;
        shift_data_in = '0;
        S_Data[0 +: 48]           = a[47:0];
        S_Data[(NL-1)*48 +: 48]   = b[47:0];
        scale_data_in[0 +: 32]    = sca[31:0];
        scale_data_in[(NC-1)*32 +: 32] = scb[31:0];
        shift_data_in[0 +: 6]     = 6'(sha);
        shift_data_in[(NC-1)*6 +: 6] = 6'(shb);
        S_Valid = 1'b1;
    endtask

    task automatic idle();
        S_Valid       = 1'b0;
        S_Data        = '0;
        scale_data_in = '0;
        shift_data_in = '0;
    endtask

    // Single beat; lane 0 uses channel 0, lane NL-1 uses channel NC-1.
    task automatic run_vec(input string tag, input int chnum, input int zp,
                           input longint a, input longint sca, input int sha,
                           input longint b, input longint scb, input int shb,
                           input longint ea, input longint eb);
        @(negedge clk);
        Channel_Out_Num_REG = 8'(chnum);
        zero_point = 8'(zp);
        set_beat(a, sca, sha, b, scb, shb);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid_early"}, longint'(M_Valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, longint'(M_Valid), 1);
        check({tag, "_lane_a"}, lane_out(0), ea);
        check({tag, "_lane_b"}, lane_out(NL-1), eb);
        check({tag, "_last"}, longint'(M_Last_Group), 1);
        check({tag, "_group"}, longint'(param_group), 0);
    endtask

    initial begin
        longint big;
        big = longint'(1) << 40;
        rst = 1'b0;
        start = 1'b0;
        Channel_Out_Num_REG = 8'd8;
        zero_point = 8'd0;
        idle();
        #12;
        check("reset_valid", longint'(M_Valid), 0);
        check("reset_last", longint'(M_Last_Group), 0);
        check("reset_group", longint'(param_group), 0);
        check("reset_data", longint'(M_Data == '0), 1);
        @(negedge clk);
        rst = 1'b1;

        run_vec("passthru", 8, 0, 1000, 1, 0, -1000, 1, 0, 127, -128);
        run_vec("round", 8, 0, 5, 1, 1, -5, 1, 1, 3, -2);
        run_vec("round_zp", 8, 10, -7, 3, 2, 300, 2, 3, 5, 85);
        run_vec("sat", 0, 0, -big, 1 << 20, 10, big, 1 << 20, 10, -128, 127);
        run_vec("negscale", 7, -5, 10, -3, 0, -3, 1, 1, -35, -6);

        // Group counter across 10 beats with 4 groups.
        @(negedge clk);
        Channel_Out_Num_REG = 8'd32;
        zero_point = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t >= 4) begin
                check($sformatf("grp_valid_%0d", t-4), longint'(M_Valid), 1);
                check($sformatf("grp_last_%0d", t-4), longint'(M_Last_Group), longint'((t-4) % 4 == 3));
                check($sformatf("grp_data_%0d", t-4), lane_out(0), longint'(t-4));
            end else begin
                check($sformatf("grp_idle_%0d", t), longint'(M_Valid), 0);
            end
            if (t < 10) begin
                check($sformatf("grp_pg_%0d", t), longint'(param_group), longint'(t % 4));
                set_beat(longint'(t), 1, 0, 0, 0, 0);
            end else begin
                idle();
            end
        end

        // Start coincident with the final-group beat.
        @(negedge clk);
        Channel_Out_Num_REG = 8'd24;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t < 3) begin
                check($sformatf("st_pg_%0d", t), longint'(param_group), longint'(t));
                set_beat(longint'(20 + t), 1, 0, 0, 0, 0);
                if (t == 2) start = 1'b1;
            end else if (t == 3) begin
                check("st_pg_cleared", longint'(param_group), 0);
                set_beat(23, 1, 0, 0, 0, 0);
            end else begin
                idle();
                check($sformatf("st_valid_%0d", t-4), longint'(M_Valid), 1);
                check($sformatf("st_data_%0d", t-4), lane_out(0), longint'(16 + t));
                check($sformatf("st_last_%0d", t-4), longint'(M_Last_Group), longint'(t == 6));
            end
        end

        // Reset in the middle of a 6-beat burst.
        @(negedge clk);
        Channel_Out_Num_REG = 8'd32;
        idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            set_beat(longint'(40 + t), 1, 0, 0, 0, 0);
        end
        @(negedge clk);
        check("rst_pre_valid", longint'(M_Valid), 1);
        check("rst_pre_data", lane_out(0), 40);
        set_beat(44, 1, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", longint'(M_Valid), 0);
        check("rst_group", longint'(param_group), 0);
        check("rst_data", longint'(M_Data == '0), 1);
        @(negedge clk);
        set_beat(45, 1, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_after_valid", longint'(M_Valid), 0);
        @(negedge clk);
        check("rst_after_pg", longint'(param_group), 0);
        set_beat(50, 1, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("rst_new_early", longint'(M_Valid), 0);
        @(negedge clk);
        check("rst_new_valid", longint'(M_Valid), 1);
        check("rst_new_data", lane_out(0), 50);
        check("rst_new_last", longint'(M_Last_Group), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_conv_quant.md
Name: image_conv_quant

Overview:
- Requantization stage directly downstream of the conv bias-add stage.
- Per beat it takes COMPUTE_CHANNEL_OUT_NUM × `PICTURE_NUM biased 48-bit accumulators and applies the per-channel scale multiply and rounding right-shift.
- It then adds the output zero point and saturates to int8, producing the packed feature data written to the output buffer.
- It also tracks the output-channel group so that the per-channel scale/shift parameters are fetched in step with the data.

Parameters:
- WIDTH_DATA_IN, 48, signed width of one biased accumulator lane.
- WIDTH_SCALE, 32, signed per-channel multiplier width.
- WIDTH_SHIFT, 6, unsigned per-channel right-shift width (0..63).
- WIDTH_DATA_OUT, 8, signed output lane width.
- COMPUTE_CHANNEL_OUT_NUM, 8, output channels per beat.
- WIDTH_FEATURE_SIZE, 10, width of channel-group counter minus one.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse at layer start; clears the group counter.
- Channel_Out_Num_REG  in  8  total output channels of the layer.
- S_Data  in  WIDTH_DATA_IN*`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM  biased sums; lane index is j*`PICTURE_NUM+i (j = channel, i = picture).
- S_Valid  in  1  S_Data valid this cycle.
- scale_data_in  in  WIDTH_SCALE*COMPUTE_CHANNEL_OUT_NUM  scale for channel j of the current group.
- shift_data_in  in  WIDTH_SHIFT*COMPUTE_CHANNEL_OUT_NUM  shift for channel j.
- zero_point  in  8  signed output zero point, layer-static.
- param_group  out  WIDTH_FEATURE_SIZE+1  channel-group index of the beat currently on S_Data; drives the zero-latency parameter memory address.
- M_Data  out  WIDTH_DATA_OUT*`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM  quantized lanes, same lane ordering as S_Data.
- M_Valid  out  1  M_Data valid.
- M_Last_Group  out  1  M_Data belongs to the final channel group.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, M_Data, M_Valid, M_Last_Group and param_group go to 0.
- Channel_Times = Channel_Out_Num_REG >> 3. A value of 0 is treated as 1.
- Group counter:
  - start=1 sets param_group to 0, with priority over a simultaneous S_Valid.
  - Otherwise each S_Valid beat increments param_group.
  - When param_group = Channel_Times-1, the beat wraps it to 0.
  - With no S_Valid, param_group holds.
- Parameters: scale_data_in and shift_data_in are sampled in the same cycle as S_Data while S_Valid=1. They are ignored when S_Valid=0.
- Pipeline: 4 stages, fixed latency 4, no backpressure. A valid shift register carries S_Valid and the last-group flag; the flag is registered when the counter equals Channel_Times-1.
  - Stage 1: p = S_lane × scale_j, full signed product of 80 bits.
  - Stage 2: if shift_j > 0 then p += 2^(shift_j-1), otherwise p is unchanged (round half up).
  - Stage 3: q = p >>> shift_j (arithmetic shift).
  - Stage 4: r = q + sign-extended zero_point, saturated to [-128, 127], then registered to M_Data.
- Data registers advance every cycle. M_Data is only meaningful when M_Valid=1.
- Back-to-back beats at one per cycle are sustained. Gaps in S_Valid produce equal gaps on M_Valid.
- A start pulse mid-stream does not flush the pipeline; beats already in flight complete with their original flags.
- An asynchronous reset mid-stream drops all in-flight beats. M_Valid stays 0 until 4 cycles after the next S_Valid.

Decomposition:
- Shared header: `PICTURE_NUM from Para.v, plus new macros `QUANT_SCALE_WIDTH (32) and `QUANT_SHIFT_WIDTH (6) for use by the parameter loader.
- One sub-module, image_quant_lane: a single-lane 4-stage multiply/round/shift/saturate pipeline, instantiated `PICTURE_NUM × COMPUTE_CHANNEL_OUT_NUM times in a generate loop.
- The top level holds the group counter, the valid/last shift register and the parameter fan-out.

Test Plan:
- Basic pass-through: lane=1000, scale=1, shift=0, zp=0 → output 127 (saturated), M_Valid exactly 4 cycles after S_Valid.
- Rounding: lane=5, scale=1, shift=1 → 3. lane=-5, scale=1, shift=1 → -2. lane=-7, scale=3, shift=2, zp=10 → 5.
- Saturation: lane=-2^40, scale=2^20, shift=10 → -128. Same magnitude positive → 127.
- Group counter: Channel_Out_Num_REG=32 with 10 consecutive beats → param_group 0,1,2,3,0,1,2,3,0,1. M_Last_Group asserted on outputs of beats 4 and 8 only.
- start pulse coincident with a beat while param_group=2 → param_group becomes 0; the in-flight beat exits with its original flags.
- Reset mid-stream: assert rst=0 during a 6-beat burst → M_Valid and param_group drop to 0 immediately. After release, the first new beat appears 4 cycles later.
